// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Handles fetch discard on flush, a bounded wait for mem_ack, and a sticky timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_stall,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, FETCH_BUSY, DATA_BUSY} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state, next_state;
  logic [7:0] wait_cnt;
  logic       discard;
  logic       last_grant_data;
  logic       fetch_want, data_want;
  logic       grant_fetch, grant_data;
  logic       acked, timed_out, flush_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_data)       next_state = DATA_BUSY;
        else if (grant_fetch) next_state = FETCH_BUSY;
      end
      FETCH_BUSY, DATA_BUSY: begin
        if (acked || timed_out) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grants are held off while a valid pulse is out, so the finishing requester can drop its request.
  always_comb begin
    fetch_want  = 1'b0;
    data_want   = 1'b0;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    acked       = 1'b0;
    timed_out   = 1'b0;
    flush_now   = 1'b0;
    case (state)
      IDLE: begin
        if (!(if_valid || d_valid)) begin
          fetch_want = if_req & ~if_flush;
          data_want  = d_rd | d_wr;
          if (fetch_want && data_want) begin
            grant_data  = ~last_grant_data;
            grant_fetch = last_grant_data;
          end else begin
            grant_data  = data_want;
            grant_fetch = fetch_want;
          end
        end
      end
      FETCH_BUSY, DATA_BUSY: begin
        acked     = mem_ack;
        timed_out = ~mem_ack & (wait_cnt == LAST_WAIT);
        flush_now = (state == FETCH_BUSY) & (discard | if_flush);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      if_valid        <= 1'b0;
      d_valid         <= 1'b0;
      if_rdata        <= '0;
      d_rdata         <= '0;
      wait_cnt        <= '0;
      discard         <= 1'b0;
      last_grant_data <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (timed_out) timeout_err <= 1'b1;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          discard  <= 1'b0;
          if (grant_data) begin
            mem_req         <= 1'b1;
            mem_we          <= d_wr;
            mem_addr        <= d_addr;
            mem_wdata       <= d_wdata;
            last_grant_data <= 1'b1;
          end else if (grant_fetch) begin
            mem_req         <= 1'b1;
            mem_we          <= 1'b0;
            mem_addr        <= if_addr;
            mem_wdata       <= '0;
            last_grant_data <= 1'b0;
          end
        end
        FETCH_BUSY: begin
          if (acked || timed_out) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
            discard  <= 1'b0;
            if (!flush_now) begin
              if_valid <= 1'b1;
              if_rdata <= acked ? mem_rdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            discard  <= flush_now;
          end
        end
        DATA_BUSY: begin
          if (acked || timed_out) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
            d_valid  <= 1'b1;
            if (timed_out)    d_rdata <= '0;
            else if (!mem_we) d_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_stall = ((d_rd | d_wr) & ~d_valid) | (if_req & ~if_valid & ~if_flush);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): fetch latency, round-robin ties,
// flush discard, timeout and reset during an access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_valid, d_valid, mem_stall, timeout_err;
  logic [31:0] if_rdata, d_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_stall(mem_stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    if_req = 1'b0; if_flush = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_d_valid", d_valid, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_stall", mem_stall, 0);
    doReset();

    // Fetch only, ack three cycles after mem_req rises
    if_req = 1'b1; if_addr = 32'h100;
    applyStimulus();
    checkOutput("f_req", mem_req, 1);
    checkOutput("f_addr", mem_addr, 32'h100);
    checkOutput("f_we", mem_we, 0);
    checkOutput("f_stall", mem_stall, 1);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("f_req_held", mem_req, 1);
    checkOutput("f_no_valid_yet", if_valid, 0);
    checkOutput("f_stall_held", mem_stall, 1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("f_valid", if_valid, 1);
    checkOutput("f_rdata", if_rdata, 32'h12345678);
    checkOutput("f_stall_drop", mem_stall, 0);
    checkOutput("f_req_drop", mem_req, 0);
    applyStimulus();
    checkOutput("f_no_regrant", mem_req, 0);
    checkOutput("f_valid_pulse", if_valid, 0);
    checkOutput("f_rdata_hold", if_rdata, 32'h12345678);
    if_req = 1'b0;

    // Tie after reset: data write first, then fetch wins the next tie
    doReset();
    if_req = 1'b1; if_addr = 32'h300;
    d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'hA5A5A5A5;
    applyStimulus();
    checkOutput("t1_req", mem_req, 1);
    checkOutput("t1_we", mem_we, 1);
    checkOutput("t1_addr", mem_addr, 32'h200);
    checkOutput("t1_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("t1_d_valid", d_valid, 1);
    checkOutput("t1_if_valid", if_valid, 0);
    checkOutput("t1_wr_rdata", d_rdata, 0);
    d_wr = 1'b0; d_rd = 1'b1; d_addr = 32'h204;
    applyStimulus();
    checkOutput("t1_blocked", mem_req, 0);
    applyStimulus();
    checkOutput("t2_req", mem_req, 1);
    checkOutput("t2_fetch_addr", mem_addr, 32'h300);
    checkOutput("t2_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("t2_if_valid", if_valid, 1);
    checkOutput("t2_if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_data_addr", mem_addr, 32'h204);
    checkOutput("t3_data_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("t3_d_valid", d_valid, 1);
    checkOutput("t3_d_rdata", d_rdata, 32'h0BADBEEF);
    d_rd = 1'b0;
    applyStimulus();

    // Flush in IDLE blocks the grant; flush while busy discards the result
    if_req = 1'b1; if_addr = 32'h400; if_flush = 1'b1;
    applyStimulus();
    checkOutput("fl_idle_block", mem_req, 0);
    checkOutput("fl_idle_stall", mem_stall, 0);
    if_flush = 1'b0;
    applyStimulus();
    checkOutput("fl_grant", mem_req, 1);
    if_flush = 1'b1;
    applyStimulus();
    if_flush = 1'b0; if_addr = 32'h500;
    mem_ack = 1'b1; mem_rdata = 32'hDEADDEAD;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("fl_no_valid", if_valid, 0);
    checkOutput("fl_rdata_hold", if_rdata, 32'hCAFEF00D);
    applyStimulus();
    checkOutput("fl_next_req", mem_req, 1);
    checkOutput("fl_next_addr", mem_addr, 32'h500);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("fl_next_valid", if_valid, 1);
    checkOutput("fl_next_rdata", if_rdata, 32'h11112222);
    if_req = 1'b0;
    applyStimulus();

    // Data read with no ack hits the timeout after four wait cycles
    d_rd = 1'b1; d_addr = 32'h600;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("to_req_4th", mem_req, 1);
    checkOutput("to_err_before", timeout_err, 0);
    applyStimulus();
    checkOutput("to_req_drop", mem_req, 0);
    checkOutput("to_d_valid", d_valid, 1);
    checkOutput("to_d_rdata", d_rdata, 0);
    checkOutput("to_err", timeout_err, 1);
    d_rd = 1'b0;
    applyStimulus();
    checkOutput("to_valid_pulse", d_valid, 0);
    checkOutput("to_err_sticky", timeout_err, 1);

    // Reset in the middle of a data access
    d_rd = 1'b1; d_addr = 32'h700;
    applyStimulus();
    checkOutput("rb_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rb_async_req", mem_req, 0);
    checkOutput("rb_err_clear", timeout_err, 0);
    d_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("rb_late_ack", d_valid, 0);
    applyStimulus();
    checkOutput("rb_late_ack2", d_valid, 0);
    checkOutput("rb_d_rdata", d_rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the width of every address bus.
REQ-002 Parameter DATA_W, default 32, sets the width of every data bus.
REQ-003 Parameter TIMEOUT, default 255, is the maximum number of wait cycles for mem_ack before abort (range 1..255).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 if_req  in  1  fetch stage requests an instruction read; held until if_valid.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_flush  in  1  discard the in-flight fetch (branch miss or jump).
REQ-009 d_rd / d_wr  in  1 each  MEM stage data read / write request; held until d_valid; never both high.
REQ-010 d_addr  in  ADDR_W, d_wdata  in  DATA_W  data access address and write data.
REQ-011 mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  shared memory port request.
REQ-012 mem_ack  in  1, mem_rdata  in  DATA_W  memory completion strobe and read data.
REQ-013 if_valid  out  1, if_rdata  out  DATA_W  fetch completion pulse and instruction.
REQ-014 d_valid  out  1, d_rdata  out  DATA_W  data completion pulse and read data.
REQ-015 mem_stall  out  1  drives mem_stall of the hazard unit.
REQ-016 timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-017 FSM states IDLE, FETCH_BUSY, DATA_BUSY.
REQ-018 IDLE: only one requester active -> grant it; both active -> grant the requester not granted last (round-robin); last_grant after reset = fetch, so data wins the first tie.
REQ-019 On grant: latch address, write data and mem_we (d_wr for data, 0 for fetch); assert mem_req from the next cycle; enter the matching BUSY state.
REQ-020 mem_req, mem_we, mem_addr and mem_wdata are registered and held constant throughout BUSY; mem_req is 0 in IDLE.
REQ-021 BUSY with mem_ack high: capture mem_rdata; pulse the granted requester's valid for exactly one cycle on the next cycle; return to IDLE; clear wait counter.
REQ-022 Minimum latency, request to valid: 2 cycles with same-cycle ack (grant edge, ack edge); a new grant never occurs in the cycle a valid pulse is output.
REQ-023 Write completion pulses d_valid; d_rdata is unchanged.
REQ-024 Wait counter (8 bit) increments each BUSY cycle without mem_ack; reaching TIMEOUT drops mem_req, pulses the requester's valid with rdata = 0, sets timeout_err, and returns to IDLE.
REQ-025 if_flush high in any FETCH_BUSY cycle, including the ack cycle, sets a discard flag; the completing fetch produces no if_valid pulse; the flag clears on return to IDLE.
REQ-026 if_flush in IDLE with if_req high blocks that cycle's fetch grant.
REQ-027 A memory access is never cancelled once mem_req is asserted, except by timeout or reset.
REQ-028 mem_stall = ((d_rd|d_wr) & ~d_valid) | (if_req & ~if_valid & ~if_flush); combinational.
REQ-029 if_rdata and d_rdata hold their last values between pulses.

Reset
REQ-030 rst_n low: immediately state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, counter=0, discard=0, last_grant=fetch, timeout_err=0.
REQ-031 Reset during BUSY abandons the access; no valid pulse after release; a late mem_ack in IDLE is ignored.
REQ-032 timeout_err clears only on reset.

Verification
REQ-033 Fetch only, if_addr=0x100, ack 3 cycles after mem_req, mem_rdata=0x12345678 -> if_valid one cycle with if_rdata=0x12345678; mem_stall high until that cycle.
REQ-034 Simultaneous if_req and d_wr (d_addr=0x200, d_wdata=0xA5A5A5A5) after reset -> data served first (mem_we=1), then fetch; second tie -> fetch first.
REQ-035 Fetch in flight, if_flush pulsed one cycle, then ack -> no if_valid; next if_req is served normally.
REQ-036 TIMEOUT=4, d_rd with no ack -> mem_req drops after 4 wait cycles; d_valid with d_rdata=0; timeout_err=1 until reset.
REQ-037 rst_n asserted mid DATA_BUSY -> mem_req=0 asynchronously; a mem_ack after release yields no d_valid.
